// File: rtl/arm_sb_pkg.sv
// Shared sizing and types for the register scoreboard.
package arm_sb_pkg;

   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned CNT_W    = 2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: saturating up/down count of in-flight writes to a single target.
// clr_i wins over inc/dec; a decrement at zero is ignored and reported on undf_o.
module sb_entry
   import arm_sb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic dec_i,
   input  logic clr_i,
   output logic busy_o,
   output logic full_o,
   output logic undf_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dec_eff;

   assign busy_o  = (cnt_q != '0);
   assign full_o  = (cnt_q == CNT_MAX);
   assign dec_eff = dec_i & busy_o;
   assign undf_o  = dec_i & ~busy_o;

   // Next count: clear, hold on inc+dec, otherwise step without wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_eff && !full_o) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (dec_eff && !inc_i) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Count state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Producer-side register hazard tracker: per-register pending counters, decode stall and a
// sticky write-back underflow flag.
// Optional SB_STATUS_TRACK_EN adds a pending counter for the NZCV status flags.
module reg_scoreboard
   import arm_sb_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid_i,
   input  logic                issue_wb_en_i,
   input  logic [ADDR_W-1:0]   issue_dest_i,
   input  logic [ADDR_W-1:0]   src1_i,
   input  logic [ADDR_W-1:0]   src2_i,
   input  logic                two_src_i,
   input  logic                wb_valid_i,
   input  logic [ADDR_W-1:0]   wb_dest_i,
   input  logic                flush_i,
   output logic                stall_o,
   output logic [NUM_REGS-1:0] busy_mask_o,
   output logic                err_underflow_o
`ifdef SB_STATUS_TRACK_EN
   ,
   input  logic                issue_s_i,
   input  logic                use_status_i,
   input  logic                wb_status_i
`endif
);

   logic [NUM_REGS-1:0] inc, dec, busy, full, undf;
   logic                stall_raw, accept, any_undf;
   logic                err_q, err_d;

   // Per-register increment/decrement decode.
   always_comb begin
      inc = '0;
      dec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         inc[r] = accept & issue_wb_en_i & (issue_dest_i == reg_idx_t'(r));
         dec[r] = wb_valid_i & (wb_dest_i == reg_idx_t'(r));
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
      sb_entry u_entry (
         .clk    (clk),
         .rst_n  (rst_n),
         .inc_i  (inc[g]),
         .dec_i  (dec[g]),
         .clr_i  (flush_i),
         .busy_o (busy[g]),
         .full_o (full[g]),
         .undf_o (undf[g])
      );
   end

`ifdef SB_STATUS_TRACK_EN
   logic st_busy, st_full, st_undf;

   sb_entry u_status (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (accept & issue_s_i),
      .dec_i  (wb_status_i),
      .clr_i  (flush_i),
      .busy_o (st_busy),
      .full_o (st_full),
      .undf_o (st_undf)
   );

   // Hazard check from registered counts only; no same-cycle write-back bypass.
   always_comb begin
      stall_raw = busy[src1_i] | (two_src_i & busy[src2_i]) |
                  (issue_wb_en_i & full[issue_dest_i]) |
                  (use_status_i & st_busy) | (issue_s_i & st_full);
      any_undf  = (|undf) | st_undf;
   end
`else
   // Hazard check from registered counts only; no same-cycle write-back bypass.
   always_comb begin
      stall_raw = busy[src1_i] | (two_src_i & busy[src2_i]) |
                  (issue_wb_en_i & full[issue_dest_i]);
      any_undf  = |undf;
   end
`endif

   assign stall_o     = issue_valid_i & stall_raw;
   assign accept      = issue_valid_i & ~stall_raw & ~flush_i;
   assign busy_mask_o = busy;

   // Sticky underflow; a write-back during flush is absorbed silently.
   always_comb begin
      err_d = err_q | (~flush_i & any_undf);
   end

   // Underflow flag state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_underflow_o = err_q;

endmodule
